// File: rtl/block_emit_pkg.sv
// Shared definitions for the block token emitter: command codes, FSM states,
// word identifiers, ASCII constants and word lengths.
package block_emit_pkg;

  localparam logic [1:0] CMD_OPEN  = 2'b00;
  localparam logic [1:0] CMD_CLOSE = 2'b01;
  localparam logic [1:0] CMD_FILL  = 2'b10;
  localparam logic [1:0] CMD_FLUSH = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEP   = 2'd1,
    S_CHAR  = 2'd2,
    S_FLUSH = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    W_BEGIN = 2'd0,
    W_END   = 2'd1,
    W_X     = 2'd2
  } word_e;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_X     = 8'h78;

  localparam logic [2:0] LEN_BEGIN = 3'd5;
  localparam logic [2:0] LEN_END   = 3'd3;
  localparam logic [2:0] LEN_X     = 3'd1;

  // Index of the final letter of a word.
  function automatic logic [2:0] word_last(input word_e w);
    case (w)
      W_BEGIN: return LEN_BEGIN - 3'd1;
      W_END:   return LEN_END - 3'd1;
      default: return LEN_X - 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/block_word_rom.sv
// Combinational letter lookup for the emitted keywords; optional uppercase
// conversion clears bit 5 (the ROM only ever yields letters).
module block_word_rom
  import block_emit_pkg::*;
(
  input  word_e      word,
  input  logic [2:0] idx,
  input  logic       upper,
  output logic [7:0] ch
);

  logic [7:0] lower;

  always_comb begin
    lower = 8'h00;
    case (word)
      W_BEGIN: begin
        case (idx)
          3'd0:    lower = 8'h62;
          3'd1:    lower = 8'h65;
          3'd2:    lower = 8'h67;
          3'd3:    lower = 8'h69;
          3'd4:    lower = 8'h6E;
          default: lower = 8'h00;
        endcase
      end
      W_END: begin
        case (idx)
          3'd0:    lower = 8'h65;
          3'd1:    lower = 8'h6E;
          3'd2:    lower = 8'h64;
          default: lower = 8'h00;
        endcase
      end
      W_X: begin
        lower = (idx == 3'd0) ? ASCII_X : 8'h00;
      end
      default: lower = 8'h00;
    endcase
    ch = upper ? (lower & 8'hDF) : lower;
  end

endmodule

// File: rtl/block_token_emitter.sv
// Serialises OPEN/CLOSE/FILL/FLUSH commands into a well-formed begin/end
// character stream. Optional uppercase support: BLOCK_EMIT_CASE_EN.
module block_token_emitter
  import block_emit_pkg::*;
#(
  parameter int DEPTH_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd,
  input  logic               cmd_upper,
  output logic               cmd_ready,
  output logic [7:0]         out_char,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DEPTH_W-1:0] depth,
  output logic               balanced,
  output logic               err
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

  state_e             state_q, state_d;
  word_e              word_q, word_d;
  logic [2:0]         idx_q, idx_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               started_q, started_d;
  logic               flush_q, flush_d;
  logic               err_q, err_d;
  logic               balanced_q, balanced_d;
  logic               rom_upper;
  logic [7:0]         rom_char;

`ifdef BLOCK_EMIT_CASE_EN
  logic upper_q, upper_d;

  always_comb begin
    upper_d = upper_q;
    if (state_q == S_IDLE && cmd_valid) begin
      upper_d = cmd_upper;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) upper_q <= 1'b0;
    else        upper_q <= upper_d;
  end

  assign rom_upper = upper_q;
`else
  logic unused_cmd_upper;
  assign unused_cmd_upper = cmd_upper;
  assign rom_upper        = 1'b0;
`endif

  block_word_rom u_rom (
    .word  (word_q),
    .idx   (idx_q),
    .upper (rom_upper),
    .ch    (rom_char)
  );

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    idx_d     = idx_q;
    depth_d   = depth_q;
    started_d = started_q;
    flush_d   = flush_q;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          idx_d = 3'd0;
          case (cmd)
            CMD_OPEN: begin
              if (depth_q == DEPTH_MAX) begin
                err_d = 1'b1;
              end else begin
                depth_d = depth_q + DEPTH_ONE;
                word_d  = W_BEGIN;
                flush_d = 1'b0;
                state_d = started_q ? S_SEP : S_CHAR;
              end
            end
            CMD_CLOSE: begin
              if (depth_q == '0) begin
                err_d = 1'b1;
              end else begin
                depth_d = depth_q - DEPTH_ONE;
                word_d  = W_END;
                flush_d = 1'b0;
                state_d = started_q ? S_SEP : S_CHAR;
              end
            end
            CMD_FILL: begin
              word_d  = W_X;
              flush_d = 1'b0;
              state_d = started_q ? S_SEP : S_CHAR;
            end
            default: begin
              // FLUSH with nothing open is silently consumed.
              if (depth_q != '0) begin
                word_d  = W_END;
                flush_d = 1'b1;
                state_d = started_q ? S_SEP : S_FLUSH;
              end
            end
          endcase
        end
      end
      S_SEP: begin
        if (out_ready) state_d = flush_q ? S_FLUSH : S_CHAR;
      end
      S_CHAR: begin
        if (out_ready) begin
          if (idx_q == word_last(word_q)) begin
            state_d   = S_IDLE;
            started_d = 1'b1;
            idx_d     = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_FLUSH: begin
        if (out_ready) begin
          if (idx_q == word_last(word_q)) begin
            // Each completed `end` closes one level; loop until none remain.
            started_d = 1'b1;
            idx_d     = 3'd0;
            depth_d   = depth_q - DEPTH_ONE;
            state_d   = (depth_q == DEPTH_ONE) ? S_IDLE : S_SEP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    balanced_d = (depth_d == '0) && (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      word_q     <= W_X;
      idx_q      <= 3'd0;
      depth_q    <= '0;
      started_q  <= 1'b0;
      flush_q    <= 1'b0;
      err_q      <= 1'b0;
      balanced_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      depth_q    <= depth_d;
      started_q  <= started_d;
      flush_q    <= flush_d;
      err_q      <= err_d;
      balanced_q <= balanced_d;
    end
  end

  always_comb begin
    out_char = 8'h00;
    case (state_q)
      S_SEP:           out_char = ASCII_SPACE;
      S_CHAR, S_FLUSH: out_char = rom_char;
      default:         out_char = 8'h00;
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign out_valid = (state_q != S_IDLE);
  assign depth     = depth_q;
  assign balanced  = balanced_q;
  assign err       = err_q;

endmodule

// File: tb/tb_block_token_emitter.sv
// Randomised bench for block_token_emitter: a queue-of-characters model
// predicts the stream, depth, balanced and err; scripted cases pin the model.
module tb_block_token_emitter;

  localparam int DW   = 2;
  localparam int DMAX = (1 << DW) - 1;

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic [1:0]    cmd;
  logic          cmd_upper;
  logic          cmd_ready;
  logic [7:0]    out_char;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] depth;
  logic          balanced;
  logic          err;

  block_token_emitter #(.DEPTH_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_upper (cmd_upper),
    .cmd_ready (cmd_ready),
    .out_char  (out_char),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .depth     (depth),
    .balanced  (balanced),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ch;
    bit         dec;
  } ent_t;

  // Compare-process state
  int    n_cmp = 0;
  int    n_bad = 0;
  ent_t  q[$];
  int    mdepth = 0;
  bit    mstarted = 0;
  bit    exp_err = 0;
  string capt = "";
  int    nerr_seen = 0;
  bit    prev_stall = 0;
  logic [7:0] prev_char = 8'h00;
  int    lit_seen = 0;
  int    to_seen = 0;

  // Driver-owned state
  bit    stall_en = 0;
  int    to_cnt = 0;
  int    lit_seq = 0;
  string lit_name = "";
  string lit_str = "";
  int    lit_depth = 0;
  int    lit_errs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got \"%s\" expected \"%s\"", name, $time, act, exp);
    end
  endtask

  task automatic push_word(input string w, input bit up, input bit dec_last);
    ent_t e;
    if (mstarted) begin
      e.ch = 8'h20; e.dec = 1'b0; q.push_back(e);
    end
    for (int i = 0; i < w.len(); i++) begin
      e.ch  = w[i];
      if (up) e.ch = e.ch - 8'd32;
      e.dec = dec_last && (i == w.len() - 1);
      q.push_back(e);
    end
    mstarted = 1'b1;
  endtask

  // Single compare process: model update and all DUT comparisons.
  initial begin
    bit   busy;
    bit   up;
    ent_t e;
    forever begin
      @(negedge clk or negedge reset);
      if (!reset) begin
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_char", 32'(out_char), 32'd0);
        check("rst_depth", 32'(depth), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        q.delete();
        mdepth = 0; mstarted = 0; exp_err = 0;
        capt = ""; nerr_seen = 0; prev_stall = 0;
      end else begin
        busy = (q.size() != 0);
        check("cmd_ready", 32'(cmd_ready), 32'(!busy));
        check("out_valid", 32'(out_valid), 32'(busy));
        check("depth", 32'(depth), 32'(mdepth));
        check("balanced", 32'(balanced), 32'(!busy && mdepth == 0));
        check("err", 32'(err), 32'(exp_err));
        if (busy) check("out_char", 32'(out_char), 32'(q[0].ch));
        if (prev_stall) check("stall_hold", 32'(out_char), 32'(prev_char));
        if (err) nerr_seen++;
        if (to_cnt != to_seen) begin
          n_cmp++; n_bad++;
          $display("FAIL handshake_timeout at %0t: got %0d timeouts expected 0", $time, to_cnt - to_seen);
          to_seen = to_cnt;
        end
        prev_stall = out_valid && !out_ready;
        prev_char  = out_char;
        exp_err    = 1'b0;
        if (busy && out_ready) begin
          e = q.pop_front();
          capt = $sformatf("%s%c", capt, e.ch);
          if (e.dec) mdepth--;
        end else if (!busy && cmd_valid) begin
`ifdef BLOCK_EMIT_CASE_EN
          up = cmd_upper;
`else
          up = 1'b0;
`endif
          case (cmd)
            2'b00: if (mdepth == DMAX) exp_err = 1'b1;
                   else begin mdepth++; push_word("begin", up, 1'b0); end
            2'b01: if (mdepth == 0) exp_err = 1'b1;
                   else begin mdepth--; push_word("end", up, 1'b0); end
            2'b10: push_word("x", up, 1'b0);
            default: for (int i = 0; i < mdepth; i++) push_word("end", up, 1'b1);
          endcase
        end
        if (lit_seq != lit_seen) begin
          lit_seen = lit_seq;
          check_str({lit_name, "_stream"}, capt, lit_str);
          check({lit_name, "_depth"}, 32'(depth), 32'(lit_depth));
          check({lit_name, "_errs"}, 32'(nerr_seen), 32'(lit_errs));
          $display("case %s: stream \"%s\" depth %0d errs %0d", lit_name, capt, depth, nerr_seen);
          capt = "";
          nerr_seen = 0;
        end
      end
    end
  end

  // out_ready driver: always ready unless the stall phase is active.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  task automatic send(input logic [1:0] c, input logic up);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    cmd = c; cmd_upper = up; cmd_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 500);
    if (!cmd_ready) to_cnt++;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd = 2'($urandom);
    cmd_upper = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 500);
    if (!cmd_ready) to_cnt++;
  endtask

  task automatic lit(input string name, input string s, input int d, input int e);
    lit_name = name; lit_str = s; lit_depth = d; lit_errs = e;
    lit_seq++;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    string up_str;
    int    r;
    cmd_valid = 1'b0; cmd = 2'b00; cmd_upper = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    send(2'b00, 1'b0); send(2'b10, 1'b0); send(2'b01, 1'b0);
    wait_idle();
    lit("basic", "begin x end", 0, 0);

    do_reset();
    send(2'b01, 1'b0); wait_idle();
    send(2'b00, 1'b0); wait_idle();
    lit("close_at_zero", "begin", 1, 1);

    do_reset();
    repeat (3) send(2'b00, 1'b0);
    send(2'b11, 1'b0); wait_idle();
    lit("flush", "begin begin begin end end end", 0, 0);

    do_reset();
    repeat (4) send(2'b00, 1'b0);
    wait_idle();
    lit("overflow", "begin begin begin", 3, 1);

    do_reset();
    send(2'b00, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    send(2'b00, 1'b1); wait_idle();
`ifdef BLOCK_EMIT_CASE_EN
    up_str = "BEGIN";
`else
    up_str = "begin";
`endif
    lit("reset_mid_word", up_str, 1, 0);

    do_reset();
    stall_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 3)      send(2'b00, 1'($urandom));
      else if (r <= 5) send(2'b01, 1'($urandom));
      else if (r <= 7) send(2'b10, 1'($urandom));
      else if (r == 8) send(2'b11, 1'($urandom));
      else             send(2'b01, 1'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end
    send(2'b11, 1'b0);
    wait_idle();
    stall_en = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/block_token_emitter.md
# block_token_emitter

Transmit-side counterpart of the begin/end block checker. Accepts block-structure commands (OPEN, CLOSE, FILL, FLUSH) over a valid/ready handshake and serialises them into an ASCII character stream, one character per cycle, with a valid/ready output handshake. The stream contains space-separated `begin`/`end` keywords and filler words, so it can be fed straight into the checker. The block tracks nesting depth so every stream it emits is well-formed: it never emits a CLOSE below depth 0 or an OPEN above the maximum depth.

## Interface
- `DEPTH_W`, 4, nesting counter width; maximum depth is 2^DEPTH_W−1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  a command is presented.
- `cmd`  in  2  command: 2'b00 OPEN (`begin`), 2'b01 CLOSE (`end`), 2'b10 FILL (`x`), 2'b11 FLUSH (close all open levels).
- `cmd_upper`  in  1  emit the word's letters in uppercase; sampled on acceptance (see Configuration).
- `cmd_ready`  out  1  command can be accepted this cycle.
- `out_char`  out  8  ASCII character.
- `out_valid`  out  1  `out_char` is valid.
- `out_ready`  in  1  downstream accepts `out_char`.
- `depth`  out  DEPTH_W  current nesting depth.
- `balanced`  out  1  high when `depth`==0 and the FSM is in IDLE.
- `err`  out  1  one-cycle pulse when an illegal command is rejected.

## Operation
- FSM states:
  - IDLE: `cmd_ready`=1, `out_valid`=0.
  - SEP: emits a space (8'h20).
  - CHAR: emits the letters of the current word.
  - FLUSH: loops the `end` word once per open level.
- A command is accepted when `cmd_valid`&&`cmd_ready`. On acceptance, the FSM goes to SEP if the `started` flag is set, otherwise to CHAR.
- The `started` flag clears on reset and sets after the first word completes. Every word except the first after reset is preceded by exactly one space. No trailing space is ever emitted.
- OPEN:
  - If `depth`==max: command is consumed, nothing is emitted, `err` pulses, FSM stays in IDLE.
  - Otherwise `depth`+1 on acceptance.
- CLOSE:
  - If `depth`==0: command is consumed, nothing is emitted, `err` pulses.
  - Otherwise `depth`−1 on acceptance.
- FILL: emits `x`; `depth` is unchanged.
- FLUSH:
  - If `depth`==0: no-op, consumed, no `err`.
  - Otherwise emits `depth` copies of (space, `end`). The space before the first copy follows the `started` rule. `depth` decrements when each `d` handshakes.
  - The FSM returns to IDLE after the last `d` handshakes.
- Output rule: while `out_valid`&&!`out_ready`, `out_char` is held stable and the FSM does not advance.
- Case: lowercase letters by default. Uppercase conversion clears bit 5 and applies only to letters, never to the space.

## Timing
- Reset (asynchronous, immediate):
  - FSM goes to IDLE.
  - `out_valid`=0, `out_char`=8'h00.
  - `depth`=0, `err`=0, `started`=0.
  - `cmd_ready`=1 once `reset` is high.
- Reset mid-word: the word is abandoned. The next word after reset carries no leading space.
- Latency:
  - The first character is valid in the cycle after acceptance.
  - With `out_ready` tied high, a command with k characters occupies k+1 cycles.
  - `cmd_ready` returns high in the cycle after the last character's handshake.
- There is no command pipelining: `cmd_ready`=0 in SEP, CHAR and FLUSH.
- Rejected commands take one cycle. `err` is high in the cycle after acceptance, and `cmd_ready` stays high.
- `depth` and `balanced` are registered. `balanced` is high from the first cycle of IDLE.

## Configuration
- `BLOCK_EMIT_CASE_EN`:
  - Defined: `cmd_upper` selects uppercase for the accepted word; the case is latched for the whole word (for FLUSH, for all its `end` words).
  - Undefined: `cmd_upper` is ignored and all letters are lowercase. The case-conversion logic is absent.

## Structure
- Package `block_emit_pkg`:
  - command encodings (`CMD_OPEN`, `CMD_CLOSE`, `CMD_FILL`, `CMD_FLUSH`);
  - the FSM state enum;
  - the ASCII constants `ASCII_SPACE` and `ASCII_X`;
  - the word-length constants (`begin`=5, `end`=3, `x`=1).
- Sub-module `block_word_rom`: combinational; inputs are word id, letter index and upper flag; output is the ASCII character. The top level keeps the FSM, index counter, depth counter and handshake logic.

## Test plan
- After reset, OPEN, FILL, CLOSE with `out_ready`=1 → stream `begin x end`; `depth` goes 1, 1, 0; `balanced`=1 at end.
- CLOSE at depth 0 → no `out_valid`; `err` pulses once; `depth` stays 0; the next OPEN emits `begin` with no leading space.
- Three OPENs then FLUSH → `begin begin begin end end end`; `depth` steps 3→2→1→0 on each `d`.
- `DEPTH_W`=2: four OPENs → the fourth is rejected with `err`; `depth`=3.
- Random `out_ready` stalls → `out_char` stable while stalled; stream identical to the no-stall run.
- Assert `reset` during `be` of `begin`, then issue OPEN → `out_valid` drops immediately; stream after reset is `begin` with no leading space. With `BLOCK_EMIT_CASE_EN` defined and `cmd_upper`=1, OPEN emits `BEGIN`.
